// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data
// access. Data has priority; a bounded data-grant streak forces fetch progress.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [STREAK_W-1:0]  r_dstreak;
  logic [STREAK_W-1:0]  w_next_dstreak;
  logic [STREAK_W-1:0]  w_streak_inc;
  logic                 w_dreq;
  logic                 w_icomplete;
  logic                 w_dcomplete;

  assign w_dreq       = dREN | dWEN;
  assign w_streak_inc = (r_dstreak >= STREAK_MAX) ? STREAK_MAX : r_dstreak + STREAK_W'(1);

  // Next-state, streak update and RAM/requester outputs from state and inputs
  always_comb begin
    w_next_state   = r_state;
    w_next_dstreak = r_dstreak;
    w_icomplete    = 1'b0;
    w_dcomplete    = 1'b0;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    iload          = '0;
    dload          = '0;

    case (r_state)
      IDLE: begin
        if (iREN && (r_dstreak == STREAK_MAX)) begin
          w_next_state = IBUS;
        end else if (w_dreq) begin
          w_next_state = DBUS;
        end else if (iREN) begin
          w_next_state = IBUS;
        end
      end

      IBUS: begin
        if (!iREN) begin
          // Requester withdrew: drop the strobe now, no completion
          w_next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            w_icomplete    = 1'b1;
            iload          = ramload;
            w_next_dstreak = '0;
            w_next_state   = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            w_next_state = IDLE;
          end
        end
      end

      DBUS: begin
        if (!w_dreq) begin
          w_next_state = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RAM_ACCESS) begin
            w_dcomplete    = 1'b1;
            dload          = dWEN ? '0 : ramload;
            w_next_dstreak = iREN ? w_streak_inc : '0;
            w_next_state   = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            w_next_state = IDLE;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    iwait = iREN & ~w_icomplete;
    dwait = w_dreq & ~w_dcomplete;
  end

  // State and data-streak registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
    end else begin
      r_state   <= w_next_state;
      r_dstreak <= w_next_dstreak;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fetch/data arbitration, streak limit,
// RAM error/busy handling and asynchronous reset.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_cmp;
  int n_err;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DSTREAK(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .iREN(iREN),
    .iaddr(iaddr),
    .iload(iload),
    .iwait(iwait),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dload(dload),
    .dwait(dwait),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge
  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    nRST     = 1'b0;
    iREN     = 1'b1;
    iaddr    = 32'h0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    ramload  = 32'h0;
    ramstate = 2'd0;

    // Reset state
    #3;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd0);
    chk("rst_dstreak", 32'(dut.r_dstreak), 32'd0);
    iREN = 1'b0;
    adv();
    nRST = 1'b1;
    adv();

    // Simple fetch: arbitration cycle then access
    iREN = 1'b1; iaddr = 32'h100;
    #1;
    chk("f1_idle_ramREN", 32'(ramREN), 32'd0);
    chk("f1_idle_iwait", 32'(iwait), 32'd1);
    adv();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1;
    chk("f1_ramREN", 32'(ramREN), 32'd1);
    chk("f1_ramaddr", ramaddr, 32'h100);
    chk("f1_iwait", 32'(iwait), 32'd0);
    chk("f1_iload", iload, 32'hDEADBEEF);
    adv();
    iREN = 1'b0; ramstate = 2'd0;
    #1;
    chk("f1_after_ramREN", 32'(ramREN), 32'd0);
    adv();

    // Fetch and write together: data first, then fetch
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
    #1;
    chk("c2_idle_iwait", 32'(iwait), 32'd1);
    chk("c2_idle_dwait", 32'(dwait), 32'd1);
    adv();
    ramstate = 2'd2; ramload = 32'h99999999;
    #1;
    chk("c2_d_ramWEN", 32'(ramWEN), 32'd1);
    chk("c2_d_ramREN", 32'(ramREN), 32'd0);
    chk("c2_d_ramaddr", ramaddr, 32'h200);
    chk("c2_d_ramstore", ramstore, 32'h1234);
    chk("c2_d_dwait", 32'(dwait), 32'd0);
    chk("c2_d_iwait", 32'(iwait), 32'd1);
    chk("c2_d_dload_wr", dload, 32'd0);
    adv();
    dWEN = 1'b0; ramstate = 2'd0;
    #1;
    chk("c2_idle2_iwait", 32'(iwait), 32'd1);
    chk("c2_streak1", 32'(dut.r_dstreak), 32'd1);
    adv();
    ramstate = 2'd2; ramload = 32'hCAFEF00D;
    #1;
    chk("c2_f_ramREN", 32'(ramREN), 32'd1);
    chk("c2_f_ramaddr", ramaddr, 32'h100);
    chk("c2_f_iwait", 32'(iwait), 32'd0);
    chk("c2_f_iload", iload, 32'hCAFEF00D);
    adv();
    iREN = 1'b0; ramstate = 2'd0;
    #1;
    chk("c2_streak0", 32'(dut.r_dstreak), 32'd0);
    adv();

    // Starvation bound: 4 data completions, then a forced fetch
    iREN = 1'b1; iaddr = 32'h180; dREN = 1'b1; daddr = 32'h300;
    ramstate = 2'd2; ramload = 32'h0000ABCD;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("s3_idle_ramREN", 32'(ramREN), 32'd0);
      chk("s3_idle_dwait", 32'(dwait), 32'd1);
      adv();
      chk("s3_d_ramaddr", ramaddr, 32'h300);
      chk("s3_d_dwait", 32'(dwait), 32'd0);
      chk("s3_d_iwait", 32'(iwait), 32'd1);
      chk("s3_d_dload", dload, 32'h0000ABCD);
      adv();
      chk("s3_streak", 32'(dut.r_dstreak), 32'(k + 1));
    end
    adv();
    #1;
    chk("s3_f_ramaddr", ramaddr, 32'h180);
    chk("s3_f_iwait", 32'(iwait), 32'd0);
    chk("s3_f_dwait", 32'(dwait), 32'd1);
    adv();
    chk("s3_streak_clr", 32'(dut.r_dstreak), 32'd0);
    adv();
    chk("s3_data_again", ramaddr, 32'h300);
    iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
    adv();

    // RAM error during fetch: retried after re-arbitration
    iREN = 1'b1; iaddr = 32'h140;
    adv();
    ramstate = 2'd3;
    #1;
    chk("e4_err_ramREN", 32'(ramREN), 32'd1);
    chk("e4_err_iwait", 32'(iwait), 32'd1);
    adv();
    ramstate = 2'd0;
    #1;
    chk("e4_idle_ramREN", 32'(ramREN), 32'd0);
    chk("e4_idle_iwait", 32'(iwait), 32'd1);
    adv();
    ramstate = 2'd2; ramload = 32'h11112222;
    #1;
    chk("e4_retry_iwait", 32'(iwait), 32'd0);
    chk("e4_retry_iload", iload, 32'h11112222);
    adv();
    iREN = 1'b0; ramstate = 2'd0;
    adv();

    // BUSY for three cycles during a data read
    dREN = 1'b1; daddr = 32'h400; ramstate = 2'd1;
    adv();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b5_busy_dwait", 32'(dwait), 32'd1);
      chk("b5_busy_ramREN", 32'(ramREN), 32'd1);
      adv();
    end
    ramstate = 2'd2; ramload = 32'h000055AA;
    #1;
    chk("b5_acc_dwait", 32'(dwait), 32'd0);
    chk("b5_acc_dload", dload, 32'h000055AA);
    adv();
    dREN = 1'b0; ramstate = 2'd0;
    adv();

    // Reset mid-write with a non-zero streak
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'h77;
    adv();
    ramstate = 2'd2;
    adv();
    ramstate = 2'd0;
    adv();
    ramstate = 2'd1;
    #1;
    chk("r6_ramWEN_pre", 32'(ramWEN), 32'd1);
    chk("r6_streak_pre", 32'(dut.r_dstreak), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("r6_ramWEN_rst", 32'(ramWEN), 32'd0);
    chk("r6_ramaddr_rst", ramaddr, 32'd0);
    chk("r6_streak_rst", 32'(dut.r_dstreak), 32'd0);
    #1;
    nRST = 1'b1;
    #1;
    chk("r6_idle_ramWEN", 32'(ramWEN), 32'd0);
    chk("r6_idle_dwait", 32'(dwait), 32'd1);
    adv();
    chk("r6_regrant_ramWEN", 32'(ramWEN), 32'd1);
    chk("r6_regrant_ramaddr", ramaddr, 32'h500);
    iREN = 1'b0; dWEN = 1'b0;
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch requester and the data-memory requester.
- Produces the iwait/dwait signals from which the hazard unit derives ihit/dhit (hit = ~wait).
- Data accesses have priority, so a stalled load/store drains first.
- A bounded-streak counter guarantees fetch progress under back-to-back data traffic.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- MAX_DSTREAK, 4, number of consecutive data grants allowed while iREN is pending before fetch is forced; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  fetch read request; held until iwait low.
- iaddr  in  ADDR_W  fetch address.
- iload  out  DATA_W  fetch data; valid when iREN & ~iwait.
- iwait  out  1  fetch not complete this cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data; valid when dREN & ~dwait.
- dwait  out  1  data access not complete this cycle.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR.

Behaviour:
- Registered state: FSM {IDLE, IBUS, DBUS} and dstreak (4 bits). Everything else is combinational from state and inputs.
- Reset (nRST low, asynchronous): state = IDLE, dstreak = 0.
  - In IDLE: ramREN, ramWEN, ramaddr, ramstore, iload and dload are all 0.
  - iwait = iREN and dwait = dREN|dWEN.
- IDLE: RAM idle. Next-state selection:
  - dreq = dREN|dWEN.
  - If iREN & (dstreak == MAX_DSTREAK) -> IBUS.
  - Else if dreq -> DBUS.
  - Else if iREN -> IBUS.
  - Else stay IDLE.
  - Arbitration therefore costs one cycle; minimum request-to-completion latency is 2 cycles.
- IBUS: ramREN = 1, ramWEN = 0, ramaddr = iaddr.
  - ramstate == ACCESS: iwait = 0, iload = ramload, dstreak <= 0, next IDLE.
  - ramstate == ERROR: iwait stays 1, next IDLE. The requester is re-arbitrated; its request is not lost.
  - iREN falls while in IBUS: abort, RAM strobes drop the same cycle, next IDLE, no completion.
- DBUS:
  - Strobes: ramWEN = dWEN, ramREN = dREN & ~dWEN.
  - Data: ramaddr = daddr, ramstore = dstore.
  - ramstate == ACCESS: dwait = 0, dload = ramload (0 when the access is a write), next IDLE.
    - If iREN is high this cycle, dstreak <= min(dstreak+1, MAX_DSTREAK); otherwise dstreak <= 0.
  - ramstate == ERROR: dwait stays 1, next IDLE.
  - dREN and dWEN both low while in DBUS: abort, next IDLE.
- Wait outputs in every state: iwait = iREN & ~icomplete; dwait = dreq & ~dcomplete. A requester that is not granted sees wait = 1.
- Only one completion per cycle; iwait and dwait are never both 0 while both requests are high.
- FREE and BUSY in a bus state: hold state and keep strobes asserted.
- Reset mid-transaction: strobes drop asynchronously and no completion is reported.

Test Plan:
- Reset then iREN=1, iaddr=0x100: cycle 1 IDLE with ramREN=0; cycle 2 ramREN=1, ramaddr=0x100, ramstate=ACCESS, ramload=0xDEADBEEF -> iwait=0, iload=0xDEADBEEF.
- iREN and dWEN raised together, daddr=0x200, dstore=0x1234 -> data granted first with ramWEN=1, ramstore=0x1234 and iwait=1 throughout; after ACCESS, the fetch is granted in the next arbitration.
- Starvation: iREN held high, dREN re-asserted every cycle, MAX_DSTREAK=4 -> exactly 4 data completions, then a fetch completion, then dstreak returns to 0.
- RAM ERROR during IBUS (ramstate=3 for one cycle) -> iwait stays 1, FSM returns to IDLE, request is re-granted, completes on a later ACCESS.
- BUSY for 3 cycles in DBUS with dREN=1 -> dwait=1 and ramREN=1 for 3 cycles; on ACCESS, dwait=0 and dload=ramload.
- nRST pulsed low during DBUS with ramWEN=1 -> ramWEN=0 immediately, dstreak=0; after release, arbitration restarts from IDLE.
